regfile8_wb: RTL and testbench

- 8-entry register file that sits at the consuming end of the 3-bit write-destination select path. That path is the 2:1 choice between the two candidate destination fields.
- Takes the selected 3-bit destination plus write-back data, decodes it into one of 8 register write enables, and serves two registered read ports.
- Keeps a pending-write scoreboard so the issue stage can stall on operands whose write-back is still outstanding.

---
 rtl/regfile8_pkg.sv | 10 +
 rtl/regfile8_wb_dec3to8.sv | 17 +
 rtl/regfile8_wb.sv | 96 +++++++++
 tb/tb_regfile8_wb.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile8_pkg.sv
// Shared register-file constants and the 3-bit register address type used by regfile8_wb
// and its decoder.
package regfile8_pkg;
  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 8;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 3'd0;
endpackage

// File: rtl/regfile8_wb_dec3to8.sv
// 3-to-8 one-hot decoder with enable.
// The output is all-zero when the enable is low.
module dec3to8
  import regfile8_pkg::*;
(
  input  logic                en_i,
  input  reg_addr_t           addr_i,
  output logic [NUM_REGS-1:0] onehot_o
);

  // NOTE: give every always_comb output a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[addr_i] = 1'b1;
  end

endmodule

// File: rtl/regfile8_wb.sv
// 8-entry write-back register file with two registered read ports and a pending-write scoreboard.
// Define REGFILE8_BYPASS_EN to forward same-cycle write data to the reads and to mask busy.
module regfile8_wb
  import regfile8_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int R0_ZERO = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  reg_addr_t           wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  input  reg_addr_t           rd_addr_a,
  output logic [WIDTH-1:0]    rd_data_a,
  input  reg_addr_t           rd_addr_b,
  output logic [WIDTH-1:0]    rd_data_b,
  input  logic                iss_en,
  input  reg_addr_t           iss_addr,
  output logic [NUM_REGS-1:0] pending,
  output logic                busy_a,
  output logic                busy_b
);

  localparam bit ZERO_R0 = (R0_ZERO != 0);
  // Registers that can hold state. With ZERO_R0 set, r0 is permanently zero and never pending.
  localparam logic [NUM_REGS-1:0] LIVE_MASK =
    ZERO_R0 ? {{(NUM_REGS-1){1'b1}}, 1'b0} : {NUM_REGS{1'b1}};

  logic [NUM_REGS-1:0] wr_vec, set_vec;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [WIDTH-1:0]    regs_q [NUM_REGS];
  logic [WIDTH-1:0]    rd_a_q, rd_a_d, rd_b_q, rd_b_d;

  dec3to8 u_wr_dec (
    .en_i    (wr_en),
    .addr_i  (wr_addr),
    .onehot_o(wr_vec)
  );

  dec3to8 u_iss_dec (
    .en_i    (iss_en),
    .addr_i  (iss_addr),
    .onehot_o(set_vec)
  );

  // A new issue to the same register supersedes the completing write, so the set is applied after the clear.
  assign pending_d = ((pending_q & ~wr_vec) | set_vec) & LIVE_MASK;

  always_comb begin
    rd_a_d = regs_q[rd_addr_a];
    rd_b_d = regs_q[rd_addr_b];
`ifdef REGFILE8_BYPASS_EN
    if (wr_vec[rd_addr_a]) rd_a_d = wr_data;
    if (wr_vec[rd_addr_b]) rd_b_d = wr_data;
`endif
    if (!LIVE_MASK[rd_addr_a]) rd_a_d = '0;
    if (!LIVE_MASK[rd_addr_b]) rd_b_d = '0;
  end

  // NOTE: this storage is flop-based and needs a defined reset value. Clearing it explicitly keeps it out of a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (wr_vec[i] && LIVE_MASK[i]) regs_q[i] <= wr_data;
    end
  end

  // NOTE: state uses non-blocking assignments, so the read ports sample the pre-edge register contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      rd_a_q    <= '0;
      rd_b_q    <= '0;
    end else begin
      pending_q <= pending_d;
      rd_a_q    <= rd_a_d;
      rd_b_q    <= rd_b_d;
    end
  end

  assign pending   = pending_q;
  assign rd_data_a = rd_a_q;
  assign rd_data_b = rd_b_q;

`ifdef REGFILE8_BYPASS_EN
  assign busy_a = pending_q[rd_addr_a] & ~wr_vec[rd_addr_a];
  assign busy_b = pending_q[rd_addr_b] & ~wr_vec[rd_addr_b];
`else
  assign busy_a = pending_q[rd_addr_a];
  assign busy_b = pending_q[rd_addr_b];
`endif

endmodule

// File: tb/tb_regfile8_wb.sv
// Self-checking bench for regfile8_wb: a driver pushes expected outputs from a behavioural model, and a negedge monitor pops and compares them.
// Directed spot checks cover reset, latency, r0, forwarding, the scoreboard and async reset.
module tb_regfile8_wb;
  import regfile8_pkg::*;

`ifdef REGFILE8_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, iss_en;
  reg_addr_t   wr_addr, rd_addr_a, rd_addr_b, iss_addr;
  logic [31:0] wr_data, rd_data_a, rd_data_b;
  logic [7:0]  pending;
  logic        busy_a, busy_b;

  regfile8_wb #(.WIDTH(32), .R0_ZERO(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr_a(rd_addr_a),
    .rd_data_a(rd_data_a),
    .rd_addr_b(rd_addr_b),
    .rd_data_b(rd_data_b),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .pending  (pending),
    .busy_a   (busy_a),
    .busy_b   (busy_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rda;
    logic [31:0] rdb;
    logic [7:0]  pend;
    logic        ba;
    logic        bb;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_regs[8];
  logic [7:0]  m_pend;
  logic [31:0] m_rda, m_rdb;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference model: the architectural register file, the set of outstanding destinations and the two output latches.
  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;
    m_pend = 8'h0;
    m_rda  = 32'h0;
    m_rdb  = 32'h0;
  endtask

  function automatic logic [31:0] m_read(input reg_addr_t a);
    if (a == 3'd0) return 32'h0;
    if (BYP && wr_en && wr_addr == a) return wr_data;
    return m_regs[a];
  endfunction

  task automatic model_step();
    logic [31:0] na, nb;
    na = m_read(rd_addr_a);
    nb = m_read(rd_addr_b);
    if (wr_en) begin
      if (wr_addr != 3'd0) m_regs[wr_addr] = wr_data;
      m_pend[wr_addr] = 1'b0;
    end
    if (iss_en) m_pend[iss_addr] = 1'b1;
    m_pend[0] = 1'b0;
    m_rda = na;
    m_rdb = nb;
  endtask

  function automatic exp_t expect_now();
    exp_t e;
    e.rda  = m_rda;
    e.rdb  = m_rdb;
    e.pend = m_pend;
    e.ba   = m_pend[rd_addr_a] && !(BYP && wr_en && wr_addr == rd_addr_a);
    e.bb   = m_pend[rd_addr_b] && !(BYP && wr_en && wr_addr == rd_addr_b);
    return e;
  endfunction

  task automatic drive(input bit we, input reg_addr_t wa, input logic [31:0] wd,
                       input reg_addr_t ra, input reg_addr_t rb,
                       input bit ie, input reg_addr_t ia);
    @(posedge clk);
    #1;
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_addr_a = ra; rd_addr_b = rb;
    iss_en = ie; iss_addr = ia;
    exp_q.push_back(expect_now());
    model_step();
  endtask

  task automatic async_reset_pulse();
    @(posedge clk);
    #1;
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'hCAFEF00D;
    iss_en = 1'b1; iss_addr = 3'd2;
    rd_addr_a = 3'd5; rd_addr_b = 3'd5;
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_pending", 32'(pending), 32'h0);
    check("async_rst_rd_a", rd_data_a, 32'h0);
    check("async_rst_rd_b", rd_data_b, 32'h0);
    wr_en = 1'b0; iss_en = 1'b0;
    model_reset();
    exp_q.push_back(expect_now());
    @(negedge clk);
    #1 rst_n = 1'b1;
    model_step();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rd_data_a", rd_data_a, e.rda);
        check("rd_data_b", rd_data_b, e.rdb);
        check("pending", 32'(pending), 32'(e.pend));
        check("busy_a", 32'(busy_a), 32'(e.ba));
        check("busy_b", 32'(busy_b), 32'(e.bb));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    rst_n = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'hDEADBEEF;
    rd_addr_a = 3'd3; rd_addr_b = 3'd3;
    iss_en = 1'b1; iss_addr = 3'd3;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check("reset_pending", 32'(pending), 32'h0);
    check("reset_rd_a", rd_data_a, 32'h0);
    check("reset_busy_b", 32'(busy_b), 32'h0);
    wr_en = 1'b0; iss_en = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    model_step();

    // Every register reads zero after reset, including r3 which saw a write during reset.
    for (int i = 0; i < 8; i++) drive(0, 3'd0, 32'h0, reg_addr_t'(i), reg_addr_t'(7 - i), 0, 3'd0);

    drive(1, 3'd5, 32'h12345678, 3'd0, 3'd0, 0, 3'd0);
    drive(0, 3'd0, 32'h0, 3'd5, 3'd0, 0, 3'd0);
    drive(0, 3'd0, 32'h0, 3'd0, 3'd0, 0, 3'd0);
    @(negedge clk);
    check("r5_latency", rd_data_a, 32'h12345678);

    drive(1, 3'd0, 32'hFFFFFFFF, 3'd0, 3'd0, 0, 3'd0);
    drive(0, 3'd0, 32'h0, 3'd0, 3'd0, 0, 3'd0);
    drive(0, 3'd0, 32'h0, 3'd0, 3'd0, 0, 3'd0);
    @(negedge clk);
    check("r0_reads_zero", rd_data_a, 32'h0);

    drive(1, 3'd2, 32'h11, 3'd0, 3'd0, 0, 3'd0);
    drive(1, 3'd2, 32'h22, 3'd2, 3'd2, 0, 3'd0);
    drive(0, 3'd0, 32'h0, 3'd0, 3'd0, 0, 3'd0);
    @(negedge clk);
    check("same_cycle_wr_rd", rd_data_a, BYP ? 32'h22 : 32'h11);

    drive(0, 3'd0, 32'h0, 3'd0, 3'd6, 1, 3'd6);
    drive(0, 3'd0, 32'h0, 3'd0, 3'd6, 0, 3'd0);
    @(negedge clk);
    check("iss6_pending", 32'(pending), 32'h40);
    check("iss6_busy_b", 32'(busy_b), 32'h1);
    drive(1, 3'd6, 32'hA5A5A5A5, 3'd0, 3'd6, 0, 3'd0);
    drive(0, 3'd0, 32'h0, 3'd0, 3'd6, 0, 3'd0);
    @(negedge clk);
    check("wr6_clears", 32'(pending), 32'h0);

    drive(0, 3'd0, 32'h0, 3'd4, 3'd1, 1, 3'd4);
    drive(1, 3'd4, 32'h44, 3'd4, 3'd1, 1, 3'd4);
    drive(0, 3'd0, 32'h0, 3'd4, 3'd1, 0, 3'd0);
    @(negedge clk);
    check("collision_set_wins", 32'(pending), 32'h10);
    drive(1, 3'd4, 32'h45, 3'd4, 3'd1, 1, 3'd1);
    drive(0, 3'd0, 32'h0, 3'd4, 3'd1, 0, 3'd0);
    @(negedge clk);
    check("set_clear_diff", 32'(pending), 32'h02);

    drive(1, 3'd1, 32'h1, 3'd5, 3'd5, 1, 3'd4);
    for (int i = 5; i < 8; i++) drive(0, 3'd0, 32'h0, 3'd5, 3'd5, 1, reg_addr_t'(i));
    drive(0, 3'd0, 32'h0, 3'd5, 3'd5, 0, 3'd0);
    @(negedge clk);
    check("pre_reset_pending", 32'(pending), 32'hF0);
    async_reset_pulse();

    repeat (400)
      drive(bit'($urandom_range(0, 1)), reg_addr_t'($urandom_range(0, 7)), $urandom(),
            reg_addr_t'($urandom_range(0, 7)), reg_addr_t'($urandom_range(0, 7)),
            bit'($urandom_range(0, 2) == 0), reg_addr_t'($urandom_range(0, 7)));

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
